jpeg_dezigzag_buffer: RTL and testbench

- Inverse of the fdct_zigzag reorder stage. It accepts 64-coefficient 8x8 blocks in JPEG zigzag order and emits them in raster (row-major) order.
- Used by the decoder and verification path as the reader side of the encoder's zigzag writer.
- Ping-pong double buffer: one bank fills while the other drains, sustaining 1 coefficient/cycle.

---
 rtl/jpeg_dezigzag_buffer.sv | 178 +++++++++++++++++
 tb/tb_jpeg_dezigzag_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_dezigzag_buffer.sv
// Purpose : zigzag-to-raster reorder of 8x8 coefficient blocks using a
//           ping-pong pair of 64-entry banks (one fills while the other drains).
// Latency : raster pos 0 is registered the cycle after the 64th input is accepted
//           (if the output register is free); 1 coefficient/cycle sustained.
// Backpressure: in_ready = !full[wr_bank]; out_data/out_first/out_last hold while
//           out_valid && !out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     input handshake, in_data in zigzag order (index = count in block)
//   out_valid/out_ready   output handshake, out_data in raster (row-major) order
//   out_first/out_last    marks raster position 0 / 63 of each block
module jpeg_dezigzag_buffer #(
    parameter int DWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_first,
    output logic              out_last
);

    // Zigzag index -> raster position of the standard JPEG scan.
    function automatic logic [5:0] zz_to_raster(input logic [5:0] idx);
        logic [5:0] r;
        r = 6'd0;
        case (idx)
            6'd0:  r = 6'd0;
            6'd1:  r = 6'd1;
            6'd2:  r = 6'd8;
            6'd3:  r = 6'd16;
            6'd4:  r = 6'd9;
            6'd5:  r = 6'd2;
            6'd6:  r = 6'd3;
            6'd7:  r = 6'd10;
            6'd8:  r = 6'd17;
            6'd9:  r = 6'd24;
            6'd10: r = 6'd32;
            6'd11: r = 6'd25;
            6'd12: r = 6'd18;
            6'd13: r = 6'd11;
            6'd14: r = 6'd4;
            6'd15: r = 6'd5;
            6'd16: r = 6'd12;
            6'd17: r = 6'd19;
            6'd18: r = 6'd26;
            6'd19: r = 6'd33;
            6'd20: r = 6'd40;
            6'd21: r = 6'd48;
            6'd22: r = 6'd41;
            6'd23: r = 6'd34;
            6'd24: r = 6'd27;
            6'd25: r = 6'd20;
            6'd26: r = 6'd13;
            6'd27: r = 6'd6;
            6'd28: r = 6'd7;
            6'd29: r = 6'd14;
            6'd30: r = 6'd21;
            6'd31: r = 6'd28;
            6'd32: r = 6'd35;
            6'd33: r = 6'd42;
            6'd34: r = 6'd49;
            6'd35: r = 6'd56;
            6'd36: r = 6'd57;
            6'd37: r = 6'd50;
            6'd38: r = 6'd43;
            6'd39: r = 6'd36;
            6'd40: r = 6'd29;
            6'd41: r = 6'd22;
            6'd42: r = 6'd15;
            6'd43: r = 6'd23;
            6'd44: r = 6'd30;
            6'd45: r = 6'd37;
            6'd46: r = 6'd44;
            6'd47: r = 6'd51;
            6'd48: r = 6'd58;
            6'd49: r = 6'd59;
            6'd50: r = 6'd52;
            6'd51: r = 6'd45;
            6'd52: r = 6'd38;
            6'd53: r = 6'd31;
            6'd54: r = 6'd39;
            6'd55: r = 6'd46;
            6'd56: r = 6'd53;
            6'd57: r = 6'd60;
            6'd58: r = 6'd61;
            6'd59: r = 6'd54;
            6'd60: r = 6'd47;
            6'd61: r = 6'd55;
            6'd62: r = 6'd62;
            6'd63: r = 6'd63;
        endcase
        return r;
    endfunction

    // Two banks of 64 coefficients; address = {bank, raster position}.
    logic [DWIDTH-1:0] mem [0:127];

    logic [5:0] wr_cnt;
    logic [5:0] rd_cnt;
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] full;

    logic       wr_fire;
    logic       load;

    assign in_ready = !full[wr_bank];
    assign wr_fire  = in_valid && in_ready;
    // Refill the output register whenever it is empty or being consumed.
    assign load     = full[rd_bank] && (!out_valid || out_ready);

    // Storage is scattered on write (zigzag -> raster) so the read side is a
    // simple linear walk. Contents are not reset; the full flags gate reads.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank, zz_to_raster(wr_cnt)}] <= in_data;
        end
    end

    // Write pointer and bank selection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt  <= 6'd0;
            wr_bank <= 1'b0;
        end else if (wr_fire) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == 6'd63) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Full flags: set by the write side on block completion, cleared by the
    // read side after the last load. A write needs !full and a drain needs
    // full, so the two never target the same bank in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (wr_fire && (wr_cnt == 6'd63)) begin
                full[wr_bank] <= 1'b1;
            end
            if (load && (rd_cnt == 6'd63)) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Read pointer and registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt    <= 6'd0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= mem[{rd_bank, rd_cnt}];
            out_valid <= 1'b1;
            out_first <= (rd_cnt == 6'd0);
            out_last  <= (rd_cnt == 6'd63);
            rd_cnt    <= rd_cnt + 6'd1;
            if (rd_cnt == 6'd63) begin
                rd_bank <= ~rd_bank;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jpeg_dezigzag_buffer.sv
// Bench for jpeg_dezigzag_buffer: a queue-based reference model built from the
// zigzag scan geometry checks every output handshake, plus directed scenarios.
module tb_jpeg_dezigzag_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_first;
    logic        out_last;

    jpeg_dezigzag_buffer #(.DWIDTH(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stall_waits = 0;

    int          zz_tab [64];     // zigzag index -> raster position
    logic [13:0] exp_q [$];       // {first, last, data}
    logic [11:0] cap [$];         // accepted outputs, in order
    logic [11:0] blk [64];
    int          part_n = 0;
    logic        stall_prev = 1'b0;
    logic [13:0] stall_val = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Walk the anti-diagonals of the 8x8 grid, alternating direction.
    function automatic void build_zz();
        int k;
        int lo;
        int hi;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_tab[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_tab[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    endfunction

    function automatic logic [11:0] cap_at(input int i);
        if (i < cap.size()) return cap[i];
        return 12'bx;
    endfunction

    // Reference model and per-cycle compare (sampled away from the active edge;
    // what is seen here is what the next rising edge will act on).
    always @(negedge clk) begin
        logic [11:0] ras [64];
        if (!rst_n) begin
            exp_q.delete();
            part_n     = 0;
            stall_prev = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_spurious", out_valid, 1'b0);
                end else begin
                    check("out_data",  out_data,  exp_q[0][11:0]);
                    check("out_first", out_first, exp_q[0][13]);
                    check("out_last",  out_last,  exp_q[0][12]);
                end
                if (stall_prev) check("stall_hold", {out_first, out_last, out_data}, stall_val);
                if (out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    cap.push_back(out_data);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_first, out_last, out_data};
            if (in_valid && in_ready) begin
                blk[part_n] = in_data;
                part_n++;
                if (part_n == 64) begin
                    for (int k = 0; k < 64; k++) ras[zz_tab[k]] = blk[k];
                    for (int p = 0; p < 64; p++) exp_q.push_back({p == 0, p == 63, ras[p]});
                    part_n = 0;
                end
            end
        end
    end

    // Called aligned to posedge+#1; returns aligned to posedge+#1 after acceptance.
    task automatic send(input logic [11:0] d);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 3000) begin
                fails++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", w);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $fatal(1, "input stalled");
            end
        end
        stall_waits += w;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_done", {31'd0, (exp_q.size() == 0 && !out_valid)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        int gaps;
        logic prod_done;

        build_zz();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Pin the scan geometry against known JPEG zigzag entries.
        check("zz2",  zz_tab[2],  8);
        check("zz5",  zz_tab[5],  2);
        check("zz20", zz_tab[20], 40);
        check("zz61", zz_tab[61], 55);
        check("zz63", zz_tab[63], 63);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last",  out_last,  0);
        check("rst_in_ready",  in_ready,  1);
        @(posedge clk); #1;

        // Single block, data = zigzag index.
        out_ready = 1'b1;
        cap.delete();
        for (int k = 0; k < 64; k++) send(12'(k));
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("lat_out_valid", out_valid, 1);
        check("lat_out_first", out_first, 1);
        check("lat_out_data",  out_data,  0);
        wait_drain(200);
        check("t1_count", cap.size(), 64);
        check("t1_out1",  cap_at(1),  1);
        check("t1_out2",  cap_at(2),  5);
        check("t1_out3",  cap_at(3),  6);
        check("t1_out8",  cap_at(8),  2);
        check("t1_out9",  cap_at(9),  4);
        check("t1_out16", cap_at(16), 3);
        check("t1_out63", cap_at(63), 63);

        // Four back-to-back blocks, continuous valid/ready.
        cap.delete();
        stall_waits = 0;
        gaps = 0;
        fork
            begin
                for (int b = 0; b < 4; b++)
                    for (int k = 0; k < 64; k++) send(12'(64 * b + k));
                in_valid = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 300);
                for (int i = 1; i < 256; i++) begin
                    @(negedge clk);
                    if (!out_valid) gaps++;
                end
            end
        join
        check("t2_in_ready_drops", stall_waits, 0);
        check("t2_out_gaps", gaps, 0);
        wait_drain(400);
        check("t2_count", cap.size(), 256);

        // Output stalled: exactly two blocks fit.
        @(posedge clk); #1;
        out_ready = 1'b0;
        cap.delete();
        acc = 0;
        in_valid = 1'b1;
        in_data = 12'd0;
        repeat (150) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            in_data = 12'(acc);
        end
        check("t3_accepted", acc, 128);
        check("t3_in_ready", in_ready, 0);
        check("t3_out_valid", out_valid, 1);
        check("t3_out_first", out_first, 1);
        check("t3_out_data", out_data, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n > 500) break;
            n++;
        end
        check("t3_in_ready_return", n, 63);
        @(posedge clk); #1;
        wait_drain(400);
        check("t3_count", cap.size(), 128);

        // Random handshakes over 20 blocks.
        cap.delete();
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1280; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send(12'($urandom_range(0, 4095)));
                end
                in_valid = 1'b0;
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    out_ready = ($urandom_range(0, 1) == 1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(5000);
        check("t4_count", cap.size(), 1280);

        // Reset with a full bank pending and a partial block.
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) send(12'(300 + k));
        for (int k = 0; k < 30; k++) send(12'(500 + k));
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t5_out_valid", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        cap.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) send(12'(1000 + k));
        in_valid = 1'b0;
        wait_drain(200);
        check("t5_count", cap.size(), 64);
        check("t5_out0",  cap_at(0),  1000);
        check("t5_out1",  cap_at(1),  1001);
        check("t5_out8",  cap_at(8),  1002);
        check("t5_out63", cap_at(63), 1063);

        // Extreme signed values pass through untouched.
        cap.delete();
        send(12'h800);
        for (int k = 1; k < 63; k++) send(12'($urandom_range(0, 4095)));
        send(12'h7FF);
        in_valid = 1'b0;
        wait_drain(200);
        check("t6_out0",  cap_at(0),  12'h800);
        check("t6_out63", cap_at(63), 12'h7FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
